// File: rtl/prbs_xnor_checker_if.sv
// Stream and status bundle between a PRBS line source and prbs_xnor_checker.
// master: the side feeding received bits; slave: the checker itself.
interface prbs_xnor_checker_if #(
  parameter int ERRW = 16
);
  logic            en;
  logic            din;
  logic            clr_cnt;
  logic            locked;
  logic            err;
  logic [ERRW-1:0] err_cnt;

  modport master (
    output en, din, clr_cnt,
    input  locked, err, err_cnt
  );

  modport slave (
    input  en, din, clr_cnt,
    output locked, err, err_cnt
  );
endinterface : prbs_xnor_checker_if

// File: rtl/prbs_xnor_checker.sv
// Receive-side checker for an XNOR-feedback PRBS stream.
// In SEARCH the local LFSR is loaded straight from the line until LOCK_CNT
// consecutive predictions hit; in LOCKED it free-runs, flags each mismatching
// bit and drops back to SEARCH when too many errors land in one window.
module prbs_xnor_checker #(
  parameter int WIDTH      = 7,
  parameter int TAP_A      = 7,
  parameter int TAP_B      = 6,
  parameter int LOCK_CNT   = 16,
  parameter int WINDOW     = 64,
  parameter int UNLOCK_ERR = 8,
  parameter int ERRW       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prbs_xnor_checker_if.slave   bus
);

  localparam int MW  = $clog2(LOCK_CNT + 1);
  localparam int WW  = $clog2(WINDOW);
  localparam int WEW = $clog2(UNLOCK_ERR + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t           state;
  logic [WIDTH-1:0] lfsr;
  logic [MW-1:0]    match_cnt;
  logic [WW-1:0]    win_cnt;
  logic [WEW-1:0]   win_err;
  logic             err_q;
  logic [ERRW-1:0]  err_cnt_q;

  // Combinational prediction and per-bit compare.
  logic             pred;
  logic             mismatch;
  logic             lockup;
  logic [WEW:0]     win_err_inc;
  logic             unlock;
  logic             err_set;

  assign pred        = ~(lfsr[TAP_A-1] ^ lfsr[TAP_B-1]);
  assign mismatch    = bus.din != pred;
  // All-ones is the XNOR lockup state: it predicts itself forever.
  assign lockup      = lfsr == {WIDTH{1'b1}};
  assign win_err_inc = {1'b0, win_err} + (WEW+1)'(mismatch);
  assign unlock      = win_err_inc >= (WEW+1)'(UNLOCK_ERR);
  assign err_set     = bus.en && (state == LOCKED) && mismatch;

  // Lock FSM, LFSR, window bookkeeping and the registered err pulse.
  // NOTE: every flop below uses <= so all updates see the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      lfsr      <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (bus.en) begin
        unique case (state)
          SEARCH: begin
            lfsr <= {lfsr[WIDTH-2:0], bus.din};
            if (!mismatch && !lockup) begin
              if (match_cnt == MW'(LOCK_CNT - 1)) begin
                state     <= LOCKED;
                match_cnt <= '0;
                win_cnt   <= '0;
                win_err   <= '0;
              end else begin
                match_cnt <= match_cnt + MW'(1);
              end
            end else begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            // Free-run on the prediction so line errors never enter the LFSR.
            lfsr  <= {lfsr[WIDTH-2:0], pred};
            err_q <= mismatch;
            if (unlock) begin
              state     <= SEARCH;
              match_cnt <= '0;
              win_cnt   <= '0;
              win_err   <= '0;
            end else if (win_cnt == WW'(WINDOW - 1)) begin
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_cnt + WW'(1);
              win_err <= win_err_inc[WEW-1:0];
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  // Saturating error counter; a clear wins over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (bus.en) begin
      if (bus.clr_cnt) begin
        err_cnt_q <= '0;
      end else if (err_set && (err_cnt_q != {ERRW{1'b1}})) begin
        err_cnt_q <= err_cnt_q + ERRW'(1);
      end
    end
  end

  assign bus.locked  = state == LOCKED;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;

endmodule : prbs_xnor_checker
